// File: rtl/div_iter.sv
// div_iter: 32-bit iterative restoring divider, signed or unsigned.
// One quotient bit is produced per cycle. A nonzero divide completes 33
// cycles after acceptance, and a zero-divisor divide completes in 2 cycles.
// result_o = {remainder, quotient}. It holds its value until the next
// completion or reset.
//
// Handshake: the initiator raises start_i with valid operands and keeps it
// high until it observes ready_o. The request is accepted in the first IDLE
// cycle with start_i=1 and annul_i=0. ready_o pulses for exactly one cycle,
// in the END state. Dropping start_i or raising annul_i while iterating
// abandons the divide silently.
module div_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_DIVZERO = 2'd1;
    localparam logic [1:0] ST_ON      = 2'd2;
    localparam logic [1:0] ST_END     = 2'd3;

    // FSM state, kept as a plain named flop so checkers can bind to it.
    logic [1:0]  state_q,   state_d;
    logic [4:0]  cnt_q,     cnt_d;
    // Working register. Bits [64:32] hold the partial remainder, and bits
    // [31:0] hold dividend bits that are shifted out as quotient bits shift in.
    logic [64:0] work_q,    work_d;
    logic [31:0] divisor_q, divisor_d;
    logic        neg_a_q,   neg_a_d;
    logic        neg_b_q,   neg_b_d;
    logic [63:0] result_q,  result_d;

    // Single restoring step on the current working register.
    logic [33:0] trial_hi;
    logic [33:0] trial_diff;
    logic [64:0] step_w;
    logic [31:0] quot_raw;
    logic [31:0] rem_raw;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    // Operand magnitudes captured at acceptance.
    logic        in_neg_a;
    logic        in_neg_b;
    logic [31:0] in_abs_a;
    logic [31:0] in_abs_b;

    // Operand sign detection and absolute values for the accept cycle.
    always_comb begin
        in_neg_a = signed_div_i & opdata1_i[31];
        in_neg_b = signed_div_i & opdata2_i[31];
        in_abs_a = in_neg_a ? (~opdata1_i + 32'd1) : opdata1_i;
        in_abs_b = in_neg_b ? (~opdata2_i + 32'd1) : opdata2_i;
    end

    // Shift-subtract step. The remainder is kept when the trial goes
    // negative. Also applies the sign fix-up used on the final step.
    always_comb begin
        trial_hi   = work_q[64:31];
        trial_diff = trial_hi - {2'b00, divisor_q};
        if (trial_diff[33]) begin
            step_w = {trial_hi[32:0], work_q[30:0], 1'b0};
        end else begin
            step_w = {trial_diff[32:0], work_q[30:0], 1'b1};
        end
        quot_raw = step_w[31:0];
        rem_raw  = step_w[63:32];
        // neg_a_q and neg_b_q are already gated by the signed flag.
        quot_fix = (neg_a_q ^ neg_b_q) ? (~quot_raw + 32'd1) : quot_raw;
        rem_fix  = neg_a_q ? (~rem_raw + 32'd1) : rem_raw;
    end

    // Next-state logic for the divider FSM and its datapath registers.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        result_d  = result_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i && !annul_i) begin
                    neg_a_d   = in_neg_a;
                    neg_b_d   = in_neg_b;
                    divisor_d = in_abs_b;
                    work_d    = {33'd0, in_abs_a};
                    cnt_d     = 5'd0;
                    state_d   = (opdata2_i == 32'd0) ? ST_DIVZERO : ST_ON;
                end
            end
            ST_DIVZERO: begin
                result_d = 64'd0;
                state_d  = ST_END;
            end
            ST_ON: begin
                // An annul or a withdrawn request wins over the last step.
                if (annul_i || !start_i) begin
                    state_d = ST_IDLE;
                end else begin
                    work_d = step_w;
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        result_d = {rem_fix, quot_fix};
                        state_d  = ST_END;
                    end
                end
            end
            ST_END: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 5'd0;
            work_q    <= 65'd0;
            divisor_q <= 32'd0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            result_q  <= 64'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            neg_a_q   <= neg_a_d;
            neg_b_q   <= neg_b_d;
            result_q  <= result_d;
        end
    end

    // ready_o is decoded from the registered state. Reset clears it at once.
    always_comb begin
        ready_o  = (state_q == ST_END);
        result_o = result_q;
    end

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter. Expected results are hand-computed.
module tb_div_iter;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int total;
    int bad;

    div_iter dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    // Clock and initial reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check64(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Drives one divide request, starting at #1 after a posedge with the DUT
    // in IDLE. Counts posedges until ready_o is seen, then checks latency and
    // result. It also checks that ready_o drops in the following cycle.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input int exp_lat,
                           input logic [63:0] exp_res, input bit keep_start,
                           input bit scramble);
        int lat;
        lat = -1;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (scramble && k == 1) begin
                opdata1_i    = $urandom_range(32'hFFFF, 1);
                opdata2_i    = $urandom_range(32'hFF, 1);
                signed_div_i = ~sgn;
            end
            if (ready_o) begin
                lat = k;
                break;
            end
        end
        check_int({tag, "_lat"}, lat, exp_lat);
        check64({tag, "_res"}, result_o, exp_res);
        if (!keep_start) start_i = 1'b0;
        @(posedge clk);
        #1;
        check64({tag, "_rdy_drop"}, {63'd0, ready_o}, 64'd0);
        check64({tag, "_res_hold"}, result_o, exp_res);
    endtask

    initial begin
        int rdy_cnt;
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        #1;
        check64("reset_result", result_o, 64'd0);
        check64("reset_ready", {63'd0, ready_o}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Unsigned 100/7, with operands disturbed mid-divide.
        run_div("u100_7", 1'b0, 32'd100, 32'd7, 33, 64'h00000002_0000000E, 1'b0, 1'b1);
        run_div("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 33, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 1'b0);
        run_div("u_fff9_2", 1'b0, 32'hFFFFFFF9, 32'd2, 33, 64'h00000001_7FFFFFFC, 1'b0, 1'b0);
        run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 33, 64'h00000001_FFFFFFFD, 1'b0, 1'b0);
        run_div("s_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 33, 64'hFFFFFFFE_0000000E, 1'b0, 1'b0);

        // Zero divisor.
        run_div("divzero_u", 1'b0, 32'h12345678, 32'd0, 2, 64'd0, 1'b0, 1'b0);
        run_div("u_10_3", 1'b0, 32'd10, 32'd3, 33, 64'h00000001_00000003, 1'b0, 1'b0);
        run_div("divzero_s", 1'b1, 32'h80000005, 32'd0, 2, 64'd0, 1'b0, 1'b0);

        // Most-negative over minus one.
        run_div("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 33, 64'h00000000_80000000, 1'b0, 1'b0);
        run_div("u_min_m1", 1'b0, 32'h80000000, 32'hFFFFFFFF, 33, 64'h80000000_00000000, 1'b0, 1'b0);

        // Idle hold: no ready_o and result stays put.
        rdy_cnt = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (ready_o) rdy_cnt++;
        end
        check_int("idle_no_ready", rdy_cnt, 0);
        check64("idle_hold", result_o, 64'h80000000_00000000);

        // Annul in the 10th ON cycle.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        rdy_cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o) rdy_cnt++;
        end
        check_int("annul_no_ready", rdy_cnt, 0);
        check64("annul_res_hold", result_o, 64'h80000000_00000000);
        run_div("u9_3", 1'b0, 32'd9, 32'd3, 33, 64'h00000000_00000003, 1'b0, 1'b0);

        // Back-to-back: start stays high across END and into the next IDLE.
        run_div("b2b_50_5", 1'b0, 32'd50, 32'd5, 33, 64'h00000000_0000000A, 1'b1, 1'b0);
        run_div("b2b_7_7", 1'b0, 32'd7, 32'd7, 33, 64'h00000000_00000001, 1'b0, 1'b0);

        // Reset mid-divide.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check64("midrst_result", result_o, 64'd0);
        check64("midrst_ready", {63'd0, ready_o}, 64'd0);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy_cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o) rdy_cnt++;
        end
        check_int("postrst_no_ready", rdy_cnt, 0);
        check64("postrst_result", result_o, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
